gc_hash_issue: RTL

- Issue stage directly upstream of the fixed-key AES pipeline and its matching NR_AES-deep 128-bit label delay line in the garbler.
- Accepts one half-gate AND request: wire labels A0, B0 and global offset R.
- Serialises it into four hash-input blocks, pt = dbl(X) ^ tweak, for X = A0, A0^R, B0, B0^R.
- Each block feeds both the AES pipeline and the delay line, so the downstream combiner forms H = AES(pt) ^ pt.

---
 rtl/gc_hash_issue_if.sv | 27 ++
 rtl/gc_hash_issue.sv | 108 ++++++++++
 2 files changed

// File: rtl/gc_hash_issue_if.sv
// rtl/gc_hash_issue_if.sv - request and hash-block handshake bundle for gc_hash_issue
interface gc_hash_issue_if #(
  parameter int N  = 128,
  parameter int TW = 64
);
  logic          cnt_clr;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_a0;
  logic [N-1:0]  in_b0;
  logic [N-1:0]  in_delta;
  logic          aes_valid;
  logic          aes_ready;
  logic [N-1:0]  aes_pt;
  logic [1:0]    aes_phase;
  logic [TW-1:0] gate_id;

  modport master (
    output cnt_clr, in_valid, in_a0, in_b0, in_delta, aes_ready,
    input  in_ready, aes_valid, aes_pt, aes_phase, gate_id
  );

  modport slave (
    input  cnt_clr, in_valid, in_a0, in_b0, in_delta, aes_ready,
    output in_ready, aes_valid, aes_pt, aes_phase, gate_id
  );
endinterface

// File: rtl/gc_hash_issue.sv
// rtl/gc_hash_issue.sv - serialises a half-gate AND request into four tweaked hash-input blocks
module gc_hash_issue #(
  parameter int N  = 128,
  parameter int TW = 64
) (
  input logic           clk,
  input logic           rst,
  gc_hash_issue_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_P0, S_P1, S_P2, S_P3} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  a0_q, b0_q, d_q, pt_q, pt_nxt;
  logic [TW-1:0] g_q, g_nxt;
  logic          busy, rdy, xfer, last, accept;
  logic [1:0]    phase;

  function automatic logic [N-1:0] dbl(input logic [N-1:0] x);
    return {x[N-2:0], 1'b0} ^ (x[N-1] ? {{(N-8){1'b0}}, 8'h87} : '0);
  endfunction

  // tweak = 2g + hi, truncated to TW bits, zero-extended to the block width
  function automatic logic [N-1:0] tweak(input logic [TW-1:0] g, input logic hi);
    logic [TW-1:0] t;
    t = {g[TW-2:0], hi};
    return N'(t);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_P0;
      S_P0:    if (xfer)   state_nxt = S_P1;
      S_P1:    if (xfer)   state_nxt = S_P2;
      S_P2:    if (xfer)   state_nxt = S_P3;
      S_P3:    if (xfer)   state_nxt = accept ? S_P0 : S_IDLE;
      default:             state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != S_IDLE);
    phase = 2'd0;
    case (state)
      S_P1:    phase = 2'd1;
      S_P2:    phase = 2'd2;
      S_P3:    phase = 2'd3;
      default: phase = 2'd0;
    endcase
    rdy = !busy | (busy & bus.aes_ready & (state == S_P3));
  end

  assign xfer   = busy & bus.aes_ready;
  assign last   = xfer & (state == S_P3);
  assign accept = bus.in_valid & rdy;

  // Clear wins over the end-of-gate increment; every newly loaded block uses g_nxt
  always_comb begin
    g_nxt = g_q;
    if (bus.cnt_clr)  g_nxt = '0;
    else if (last)    g_nxt = g_q + 1'b1;
  end

  always_comb begin
    pt_nxt = pt_q;
    if (accept) begin
      pt_nxt = dbl(bus.in_a0) ^ tweak(g_nxt, 1'b0);
    end else if (xfer) begin
      case (state)
        S_P0:    pt_nxt = dbl(a0_q ^ d_q) ^ tweak(g_nxt, 1'b0);
        S_P1:    pt_nxt = dbl(b0_q)       ^ tweak(g_nxt, 1'b1);
        S_P2:    pt_nxt = dbl(b0_q ^ d_q) ^ tweak(g_nxt, 1'b1);
        default: pt_nxt = pt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a0_q <= '0;
      b0_q <= '0;
      d_q  <= '0;
      pt_q <= '0;
      g_q  <= '0;
    end else begin
      pt_q <= pt_nxt;
      g_q  <= g_nxt;
      if (accept) begin
        a0_q <= bus.in_a0;
        b0_q <= bus.in_b0;
        d_q  <= bus.in_delta;
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.aes_valid = busy;
  assign bus.aes_phase = phase;
  assign bus.aes_pt    = pt_q;
  assign bus.gate_id   = g_q;

endmodule
